// File: rtl/multdiv_ctrl.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (non-restoring) controller on one shared add/sub/shift datapath.
// Build option: define MULTDIV_ZERO_BYPASS_EN to complete zero-operand multiplies/divides in one cycle.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        data_busy
);

`ifdef MULTDIV_ZERO_BYPASS_EN
  localparam bit zero_bypass = 1'b1;
`else
  localparam bit zero_bypass = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic [32:0] acc, acc_next;   // Booth P (sign-extended) or division remainder R
  logic [31:0] q, q_next;       // Booth multiplier/low product or dividend/quotient
  logic        q_m1, q_m1_next;
  logic [31:0] m, m_next;       // multiplicand or divisor magnitude
  logic        neg, neg_next;
  logic        ovf, ovf_next;
  logic [31:0] res_next;
  logic        exc_next;

  logic [32:0] add_a, add_b, sum;
  logic        add_sub;
  logic [32:0] prod_hi;
  logic [31:0] a_mag, b_mag;

  assign a_mag = data_operandA[31] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[31] ? -data_operandB : data_operandB;

  // Shared adder: operand routing depends only on registered state, so no combinational loop.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      MUL: begin
        add_a   = acc;
        add_sub = q[0] & ~q_m1;
        if (q[0] != q_m1) add_b = {m[31], m};
      end
      DIV: begin
        add_a   = {acc[31:0], q[31]};
        add_b   = {1'b0, m};
        add_sub = ~acc[32];
      end
      FIX: begin
        add_a = acc;
        add_b = {1'b0, m};
      end
      default: ;
    endcase
  end

  assign sum = add_sub ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latches).
    state_next = state;
    cnt_next   = cnt;
    acc_next   = acc;
    q_next     = q;
    q_m1_next  = q_m1;
    m_next     = m;
    neg_next   = neg;
    ovf_next   = ovf;
    res_next   = data_result;
    exc_next   = data_exception;
    prod_hi    = '0;

    case (state)
      MUL: begin
        acc_next  = {sum[32], sum[32:1]};
        q_next    = {sum[0], q[31:1]};
        q_m1_next = q[0];
        cnt_next  = cnt + 5'd1;
        if (cnt == 5'd31) begin
          prod_hi    = {acc_next[31:0], q_next[31]};
          res_next   = q_next;
          exc_next   = !((prod_hi == '0) || (prod_hi == '1));
          state_next = DONE;
        end
      end
      DIV: begin
        acc_next = sum;
        q_next   = {q[30:0], ~sum[32]};
        cnt_next = cnt + 5'd1;
        if (cnt == 5'd31) state_next = FIX;
      end
      FIX: begin
        if (acc[32]) acc_next = sum;
        res_next   = neg ? -q : q;
        exc_next   = ovf;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A start pulse in any state aborts whatever is in flight; MULT wins over DIV.
    if (ctrl_MULT || ctrl_DIV) begin
      res_next  = data_result;
      exc_next  = data_exception;
      cnt_next  = '0;
      acc_next  = '0;
      q_m1_next = 1'b0;
      if (ctrl_MULT) begin
        q_next     = data_operandB;
        m_next     = data_operandA;
        neg_next   = 1'b0;
        ovf_next   = 1'b0;
        state_next = MUL;
        if (zero_bypass && (data_operandA == '0 || data_operandB == '0)) begin
          res_next   = '0;
          exc_next   = 1'b0;
          state_next = DONE;
        end
      end else begin
        q_next     = a_mag;
        m_next     = b_mag;
        neg_next   = data_operandA[31] ^ data_operandB[31];
        ovf_next   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        state_next = DIV;
        if (data_operandB == '0) begin
          res_next   = '0;
          exc_next   = 1'b1;
          state_next = DONE;
        end else if (zero_bypass && data_operandA == '0) begin
          res_next   = '0;
          exc_next   = 1'b0;
          state_next = DONE;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      q              <= '0;
      q_m1           <= 1'b0;
      m              <= '0;
      neg            <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      acc            <= acc_next;
      q              <= q_next;
      q_m1           <= q_m1_next;
      m              <= m_next;
      neg            <= neg_next;
      ovf            <= ovf_next;
      data_result    <= res_next;
      data_exception <= exc_next;
    end
  end

  assign data_resultRDY = (state == DONE);
  assign data_busy      = (state == MUL) || (state == DIV) || (state == FIX);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: an arithmetic reference model predicts result, exception and RDY cycle per start.
module tb_multdiv_ctrl;

`ifdef MULTDIV_ZERO_BYPASS_EN
  localparam bit bypass = 1'b1;
`else
  localparam bit bypass = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        data_busy;

  multdiv_ctrl dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .data_busy      (data_busy)
  );

  typedef struct {
    int          start;
    int          rdy;
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [31:0] hold_res = '0;
  logic        hold_exc = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain signed 64-bit arithmetic plus the latency rules.
  function automatic exp_t model(input bit is_mul, input logic [31:0] a, input logic [31:0] b, input int s);
    exp_t        e;
    longint      p;
    logic [31:0] lo;
    e.start = s;
    if (is_mul) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      lo    = p[31:0];
      e.res = lo;
      e.exc = (p != longint'($signed(lo)));
      e.rdy = s + ((bypass && (a == 0 || b == 0)) ? 1 : 33);
    end else if (b == 0) begin
      e.res = '0;
      e.exc = 1'b1;
      e.rdy = s + 1;
    end else begin
      p     = longint'($signed(a)) / longint'($signed(b));
      lo    = p[31:0];
      e.res = lo;
      e.exc = (p > 64'sd2147483647);
      e.rdy = s + ((bypass && a == 0) ? 1 : 34);
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
    if (sb.size() > 0 && sb[$].rdy > cyc) void'(sb.pop_back());
    sb.push_back(model(mul, a, b, cyc));
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    tick(1);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_timeout", longint'(sb.size()), longint'(0));
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'h0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'($urandom_range(0, 20)) - 32'd10;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Monitor: checks busy every cycle, pops on RDY, and checks result hold between RDYs.
  always @(negedge clock) begin
    exp_t e;
    bit   exp_busy;
    if (!reset_n) begin
      sb.delete();
      hold_res = '0;
      hold_exc = 1'b0;
      check("reset_result", longint'(data_result), longint'(0));
      check("reset_exception", longint'(data_exception), longint'(0));
      check("reset_rdy", longint'(data_resultRDY), longint'(0));
      check("reset_busy", longint'(data_busy), longint'(0));
    end else begin
      exp_busy = 1'b0;
      foreach (sb[i]) if (sb[i].start < cyc && cyc < sb[i].rdy) exp_busy = 1'b1;
      check("busy", longint'(data_busy), longint'(exp_busy));
      if (sb.size() > 0 && cyc > sb[0].rdy) begin
        check("rdy_missing_cycle", longint'(cyc), longint'(sb[0].rdy));
        void'(sb.pop_front());
      end
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          check("rdy_unexpected", longint'(data_resultRDY), longint'(0));
        end else begin
          e = sb.pop_front();
          check("rdy_cycle", longint'(cyc), longint'(e.rdy));
          check("result", longint'(data_result), longint'(e.res));
          check("exception", longint'(data_exception), longint'(e.exc));
          hold_res = e.res;
          hold_exc = e.exc;
        end
      end else begin
        check("hold_result", longint'(data_result), longint'(hold_res));
        check("hold_exception", longint'(data_exception), longint'(hold_exc));
      end
    end
  end

  initial begin
    int target;
    bit mul;
    bit both;
    #2 reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
    check("init_result", longint'(data_result), longint'(0));
    check("init_exception", longint'(data_exception), longint'(0));
    check("init_rdy", longint'(data_resultRDY), longint'(0));
    check("init_busy", longint'(data_busy), longint'(0));

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done();
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done();
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done();
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    start_op(1'b1, 1'b1, 32'd6, 32'd7);
    wait_done();

    // Restart: DIV pulse ten cycles into a MULT replaces it.
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    tick(9);
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done();

    // Reset in the middle of a MULT: no RDY may follow.
    start_op(1'b1, 1'b0, 32'd11, 32'd13);
    tick(14);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(45);

    start_op(1'b1, 1'b0, 32'd0, 32'd9);
    wait_done();
    start_op(1'b0, 1'b1, 32'd0, 32'd5);
    wait_done();

    // Back-to-back: new start on the old op's RDY cycle.
    start_op(1'b1, 1'b0, 32'hFFFF_FF00, 32'd77);
    target = sb[$].rdy;
    while (cyc < target) tick(1);
    start_op(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF0);
    wait_done();

    for (int i = 0; i < 60; i++) begin
      mul  = ($urandom_range(0, 1) == 1);
      both = ($urandom_range(0, 9) == 0);
      start_op(mul | both, !mul | both, rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(0, 40)));
      else wait_done();
    end
    wait_done();
    tick(40);
    check("final_queue_empty", longint'(sb.size()), longint'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
